// File: rtl/us_delay_timer_if.sv
// Handshake bundle between game logic and the microsecond delay timer.
// Ports: tick/start/delay/periodic/abort toward the timer; busy/done/remaining back.
interface us_delay_timer_if #(
    parameter int WIDTH = 20
);
    logic             i_tick;
    logic             i_start;
    logic [WIDTH-1:0] i_delay;
    logic             i_periodic;
    logic             i_abort;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_remaining;

    modport master (
        output i_tick,
        output i_start,
        output i_delay,
        output i_periodic,
        output i_abort,
        input  o_busy,
        input  o_done,
        input  o_remaining
    );

    modport slave (
        input  i_tick,
        input  i_start,
        input  i_delay,
        input  i_periodic,
        input  i_abort,
        output o_busy,
        output o_done,
        output o_remaining
    );
endinterface

// File: rtl/us_delay_timer.sv
// Counts a programmable number of 1 us ticks, pulses done, optional auto-reload.
// Ports: i_clk_25MHz, i_reset (sync, active-high), bus (slave side of us_delay_timer_if).
module us_delay_timer #(
    parameter int WIDTH = 20
) (
    input  logic              i_clk_25MHz,
    input  logic              i_reset,
    us_delay_timer_if.slave   bus
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] remaining;
    logic [WIDTH-1:0] reload;
    logic             periodic;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge i_clk_25MHz) begin
        if (i_reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= ZERO;
            reload    <= ZERO;
            periodic  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus.i_abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                remaining <= ZERO;
            end else if (bus.i_start) begin
                // A start always swallows a coincident tick.
                if (bus.i_delay != ZERO) begin
                    state     <= RUN;
                    busy      <= 1'b1;
                    remaining <= bus.i_delay;
                    reload    <= bus.i_delay;
                    periodic  <= bus.i_periodic;
                end else begin
                    // Zero delay: single immediate pulse, never a pulse train.
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    remaining <= ZERO;
                end
            end else if (bus.i_tick && state == RUN) begin
                if (remaining == ONE) begin
                    done <= 1'b1;
                    if (periodic) begin
                        remaining <= reload;
                    end else begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        remaining <= ZERO;
                    end
                end else begin
                    remaining <= remaining - ONE;
                end
            end
        end
    end

    assign bus.o_busy      = busy;
    assign bus.o_done      = done;
    assign bus.o_remaining = remaining;

endmodule

// File: tb/tb_us_delay_timer.sv
// Self-checking bench for us_delay_timer: directed scenarios plus random traffic.
// Expected outputs are queued per clock and compared by an independent monitor.
module tb_us_delay_timer;

    localparam int W = 20;

    typedef struct {
        bit          busy;
        bit          done;
        int unsigned rem;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    us_delay_timer_if #(.WIDTH(W)) bus ();

    us_delay_timer #(.WIDTH(W)) dut (
        .i_clk_25MHz (clk),
        .i_reset     (rst),
        .bus         (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: a timer is either idle or armed with a count of ticks left.
    bit          m_armed;
    int unsigned m_left;
    int unsigned m_reload;
    bit          m_repeat;
    bit          last_tk;
    int          phase;

    function automatic exp_t model(input bit tk, input bit st,
                                   input int unsigned d, input bit p,
                                   input bit ab, input bit rs);
        exp_t e;
        e.done = 0;
        if (rs) begin
            m_armed  = 0;
            m_left   = 0;
            m_reload = 0;
            m_repeat = 0;
        end else if (ab) begin
            m_armed = 0;
            m_left  = 0;
        end else if (st) begin
            if (d == 0) begin
                e.done  = 1;
                m_armed = 0;
                m_left  = 0;
            end else begin
                m_armed  = 1;
                m_left   = d;
                m_reload = d;
                m_repeat = p;
            end
        end else if (tk && m_armed) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                e.done = 1;
                if (m_repeat) m_left = m_reload;
                else m_armed = 0;
            end
        end
        e.busy = m_armed;
        e.rem  = m_left;
        return e;
    endfunction

    task automatic step(input bit tk, input bit st, input int unsigned d,
                        input bit p, input bit ab, input bit rs);
        exp_t e;
        if (last_tk) tk = 0;
        last_tk        = tk;
        bus.i_tick     = tk;
        bus.i_start    = st;
        bus.i_delay    = W'(d);
        bus.i_periodic = p;
        bus.i_abort    = ab;
        rst            = rs;
        e = model(tk, st, d, p, ab, rs);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Idle cycles with a tick every 36 clocks.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step(phase == 35, 0, 0, 0, 0, 0);
            phase = (phase + 1) % 36;
        end
    endtask

    task automatic run_until_left(input int unsigned target);
        int guard = 0;
        while (m_left != target && guard < 2000) begin
            run(1);
            guard++;
        end
        checks++;
        if (m_left != target) begin
            errors++;
            $display("FAIL reach_left: got %0d want %0d", m_left, target);
        end
    endtask

    initial begin : monitor
        exp_t e;
        bit   prev_done;
        prev_done = 0;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.o_busy !== e.busy) begin
                    errors++;
                    $display("FAIL busy @%0t: got %b want %b",
                             $time, bus.o_busy, e.busy);
                end
                checks++;
                if (bus.o_done !== e.done) begin
                    errors++;
                    $display("FAIL done @%0t: got %b want %b",
                             $time, bus.o_done, e.done);
                end
                checks++;
                if (bus.o_remaining !== W'(e.rem)) begin
                    errors++;
                    $display("FAIL remaining @%0t: got %0d want %0d",
                             $time, bus.o_remaining, e.rem);
                end
                checks++;
                if (bus.o_done === 1'b1 && prev_done) begin
                    errors++;
                    $display("FAIL done_twice @%0t: got 1 want 0", $time);
                end
                prev_done = (bus.o_done === 1'b1);
            end
        end
    end

    initial begin
        bit          tk, st, p, ab, rs;
        int unsigned d;
        last_tk  = 0;
        phase    = 0;
        m_armed  = 0;
        m_left   = 0;
        m_reload = 0;
        m_repeat = 0;

        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // One-shot, delay 3.
        step(0, 1, 3, 0, 0, 0);
        run(36 * 4);

        // Periodic, delay 2, then abort.
        step(0, 1, 2, 1, 0, 0);
        run(36 * 7);
        step(0, 0, 0, 0, 1, 0);
        run(36 * 3);

        // Start coincident with a tick.
        while (phase != 35) run(1);
        step(1, 1, 1, 0, 0, 0);
        phase = 0;
        run(40);

        // Zero delay, one-shot and periodic.
        step(0, 1, 0, 0, 0, 0);
        run(3);
        step(0, 1, 0, 1, 0, 0);
        run(5);

        // Retrigger at one tick left.
        step(0, 1, 2, 0, 0, 0);
        run_until_left(1);
        step(0, 1, 5, 0, 0, 0);
        run(36 * 6);

        // Reset mid-count, then ticks do nothing.
        step(0, 1, 4, 1, 0, 0);
        run_until_left(2);
        step(0, 0, 0, 0, 0, 1);
        run(36 * 3);

        // Abort together with start.
        step(0, 1, 3, 0, 0, 0);
        run(10);
        step(0, 1, 6, 1, 1, 0);
        run(40);

        // Random traffic.
        for (int i = 0; i < 5000; i++) begin
            tk = ($urandom_range(3) == 0);
            st = ($urandom_range(29) == 0);
            if ($urandom_range(15) == 0) d = $urandom_range((1 << W) - 1);
            else d = $urandom_range(6);
            p  = $urandom_range(1);
            ab = ($urandom_range(149) == 0);
            rs = ($urandom_range(499) == 0);
            step(tk, st, d, p, ab, rs);
        end

        run(4);
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
